// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Frame layout: ADDR, LEN (count-1), payload bytes, CHK.
`timescale 1ns/1ps
package loader_pkg;

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } loader_state_e;

  localparam int FRAME_FIELD_ADDR = 0;
  localparam int FRAME_FIELD_LEN  = 1;
  localparam int FRAME_FIELD_DATA = 2;
  localparam int FRAME_FIELD_CHK  = 3;

  localparam logic [7:0] LOADER_SUM_OK = 8'h00;

  function automatic logic is_loading(
    input loader_state_e st
  );
    return (st == ST_ADDR) || (st == ST_LEN) ||
           (st == ST_DATA) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit payload sum with a combinational match
// test for a candidate trailing checksum byte.
`timescale 1ns/1ps
module loader_checksum
  import loader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] byte_i,
  input  logic [W-1:0] cand_i,
  output logic         match_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;
  logic [W-1:0] total;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign total   = sum_q + cand_i;
  assign match_o = (total == W'(LOADER_SUM_OK));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes payload to memory and
// releases the CPU from reset once the checksum verifies.
`timescale 1ns/1ps
module program_loader
  import loader_pkg::*;
#(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 load_req,
  output logic [word_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  output logic                 cpu_rst_n,
  output logic                 done,
  output logic                 err
);

  localparam logic [word_size-1:0] ONE = 1;

  loader_state_e state_q, state_d;

  logic [word_size-1:0] ptr_q, ptr_d;
  logic [word_size-1:0] cnt_q, cnt_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic xfer;
  logic sum_clr;
  logic sum_add;
  logic sum_match;

  assign in_ready = is_loading(state_q);
  assign xfer     = in_valid & in_ready;

  loader_checksum #(
    .W (word_size)
  ) u_checksum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sum_clr),
    .add_i   (sum_add),
    .byte_i  (in_data),
    .cand_i  (in_data),
    .match_o (sum_match)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    run_d   = run_q;
    done_d  = done_q;
    err_d   = err_q;
    sum_clr = 1'b0;
    sum_add = 1'b0;
    unique case (state_q)
      ST_ADDR: begin
        if (xfer) begin
          ptr_d   = in_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          cnt_d   = in_data;
          sum_clr = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          addr_d  = ptr_q;
          data_d  = in_data;
          wr_d    = 1'b1;
          ptr_d   = ptr_q + ONE;
          sum_add = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_CHK;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          if (sum_match) begin
            state_d = ST_RUN;
            run_d   = 1'b1;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = ST_ERR;
            run_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      ST_RUN, ST_ERR: begin
        // Restart holds the CPU in reset again on this edge.
        if (load_req) begin
          state_d = ST_ADDR;
          run_d   = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ADDR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_write   = wr_q;
  assign cpu_rst_n   = run_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard
// and a behavioural memory on the write port.
`timescale 1ns/1ps
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       load_req = 1'b0;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_write;
  logic       cpu_rst_n;
  logic       done;
  logic       err;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [7:0]  pl [$];
  logic [7:0]  snap42;
  logic [7:0]  snap43;
  int n_checks = 0;
  int n_fail   = 0;

  program_loader #(
    .word_size (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .load_req    (load_req),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_write   (mem_write),
    .cpu_rst_n   (cpu_rst_n),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write === 1'b1) mem[mem_address] <= mem_data;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && mem_write !== 1'b0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      check("write", {16'h0, mem_address, mem_data}, {16'h0, e});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    check("in_ready", {31'h0, in_ready}, 32'h1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_no_write", {31'h0, mem_write}, 32'h0);
    end
  endtask

  task automatic send_payload(input logic [7:0] a,
                              input int from,
                              input int to);
    for (int i = from; i < to; i++) begin
      exp_q.push_back({a + 8'(i), pl[i]});
      send_byte(pl[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] a,
                            input logic [7:0] chk);
    send_byte(a);
    send_byte(8'(pl.size() - 1));
    send_payload(a, 0, pl.size());
    send_byte(chk);
  endtask

  task automatic restart();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_cpu", {31'h0, cpu_rst_n}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic expect_status(input string tag,
                               input logic d,
                               input logic e,
                               input logic c);
    check({tag, "_done"}, {31'h0, done}, {31'h0, d});
    check({tag, "_err"}, {31'h0, err}, {31'h0, e});
    check({tag, "_cpu"}, {31'h0, cpu_rst_n}, {31'h0, c});
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #2;
    check("reset_addr", {24'h0, mem_address}, 32'h0);
    check("reset_data", {24'h0, mem_data}, 32'h0);
    check("reset_write", {31'h0, mem_write}, 32'h0);
    expect_status("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", {31'h0, in_ready}, 32'h1);

    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'h10, 8'hCF);
    expect_status("f1", 1'b1, 1'b0, 1'b1);
    check("f1_ready", {31'h0, in_ready}, 32'h0);
    check("f1_mem10", {24'h0, mem[8'h10]}, 32'hAA);
    check("f1_mem12", {24'h0, mem[8'h12]}, 32'hCC);
    idle(2);
    expect_status("f1_hold", 1'b1, 1'b0, 1'b1);

    restart();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'hFE, 8'hF6);
    expect_status("wrap", 1'b1, 1'b0, 1'b1);
    check("wrap_memFF", {24'h0, mem[8'hFF]}, 32'h02);
    check("wrap_mem00", {24'h0, mem[8'h00]}, 32'h03);
    check("wrap_mem01", {24'h0, mem[8'h01]}, 32'h04);

    restart();
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_byte(8'h10);
    load_req = 1'b1;
    send_byte(8'h02);
    send_payload(8'h10, 0, 1);
    load_req = 1'b0;
    send_payload(8'h10, 1, 3);
    send_byte(8'h00);
    expect_status("bad", 1'b0, 1'b1, 1'b0);
    restart();
    send_frame(8'h10, 8'hCF);
    expect_status("reload", 1'b1, 1'b0, 1'b1);

    restart();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_byte(8'h20);
    send_byte(8'h03);
    send_payload(8'h20, 0, 1);
    idle(2);
    send_payload(8'h20, 1, 4);
    idle(1);
    send_byte(8'h56);
    expect_status("gap", 1'b1, 1'b0, 1'b1);
    check("gap_mem21", {24'h0, mem[8'h21]}, 32'h22);

    restart();
    snap42 = mem[8'h42];
    snap43 = mem[8'h43];
    pl = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    send_byte(8'h40);
    send_byte(8'h03);
    send_payload(8'h40, 0, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_write", {31'h0, mem_write}, 32'h0);
    check("abort_addr", {24'h0, mem_address}, 32'h0);
    expect_status("abort", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("abort_mem40", {24'h0, mem[8'h40]}, 32'h5A);
    check("abort_mem41", {24'h0, mem[8'h41]}, 32'h5B);
    check("abort_mem42", {24'h0, mem[8'h42]}, {24'h0, snap42});
    check("abort_mem43", {24'h0, mem[8'h43]}, {24'h0, snap43});
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'h40, 8'hF6);
    expect_status("fresh", 1'b1, 1'b0, 1'b1);
    check("fresh_mem43", {24'h0, mem[8'h43]}, 32'h04);

    restart();
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'h01);
    send_frame(8'h80, 8'h00);
    expect_status("full", 1'b1, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== 8'h01) bad++;
    end
    check("full_mem_all", bad, 0);

    idle(2);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the stored-program machine. It accepts a framed byte stream over a valid/ready handshake and writes the payload into the 256-word memory through the memory write port. Until a frame has been written and its checksum verified, it holds the processor and controller in reset. It sits between an external host link and the memory's write side, with the CPU's own memory port muxed out while loading. The mux is external and is selected by `cpu_rst_n`.

## Interface
Parameters:
- `word_size`, 8, data and address width; the memory depth is 2^word_size.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  word_size  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer happens when `in_valid & in_ready` at a rising edge.
- `load_req`  in  1  restart loading; sampled only in RUN or ERR.
- `mem_address`  out  word_size  memory write address.
- `mem_data`  out  word_size  memory write data.
- `mem_write`  out  1  memory write strobe; memory captures on the next rising edge.
- `cpu_rst_n`  out  1  active-low reset to the processor and controller.
- `done`  out  1  frame loaded and verified.
- `err`  out  1  checksum mismatch on the last frame.

## Operation
Frame format, in order:
- ADDR: start address.
- LEN: payload length minus 1, so 1–256 bytes.
- N payload bytes.
- CHK: two's-complement checksum; the 8-bit sum of all payload bytes plus CHK must equal 0.

States and transitions:
- ADDR: `in_ready`=1. On transfer, `ptr`←byte, go to LEN.
- LEN: `in_ready`=1. On transfer, `cnt`←byte, `sum`←0, go to DATA.
- DATA: `in_ready`=1. On each transfer:
  - register `mem_address`←`ptr`, `mem_data`←byte, `mem_write`←1;
  - `ptr`←`ptr`+1 mod 256;
  - `sum`←`sum`+byte mod 256;
  - if `cnt`==0 go to CHK, else `cnt`←`cnt`−1.
- CHK: `in_ready`=1. On transfer, if (`sum`+byte)[7:0]==0 go to RUN, else go to ERR.
- RUN: `in_ready`=0, `done`=1, `cpu_rst_n`=1.
- ERR: `in_ready`=0, `err`=1, `cpu_rst_n`=0.
- In RUN or ERR, `load_req`=1 → ADDR. This clears `done` and `err` and drops `cpu_rst_n` to 0 on that edge.

Boundary rules:
- `mem_write` is 1 for exactly one cycle per accepted payload byte. It is 0 in every other cycle, including DATA cycles with no transfer.
- An address wrap from 0xFF to 0x00 mid-frame is legal and silent.
- `in_valid` gaps in any state stall the FSM with no side effects.
- `load_req` in states ADDR through CHK is ignored.
- `rst` asserted mid-frame aborts the frame. Bytes already written stay in memory, and the FSM returns to ADDR.

## Timing
Reset values while `rst`=1, all asynchronous:
- state=ADDR, `ptr`=0, `cnt`=0, `sum`=0;
- `mem_address`=0, `mem_data`=0, `mem_write`=0;
- `cpu_rst_n`=0, `done`=0, `err`=0;
- `in_ready`=1 once `rst` deasserts.

Cycle-level behaviour:
- All outputs are registered except `in_ready`, which decodes the state.
- Throughput is one byte per cycle in every loading state. No backpressure is needed because the memory accepts a write every cycle.
- Write latency: byte accepted at edge k gives `mem_write`=1 from k to k+1, and memory is updated at edge k+1.
- CHK accepted at edge k puts `cpu_rst_n`/`done` (or `err`) high after edge k. The final payload write, registered at edge k−1 or earlier, has already completed by edge k.
- The minimum frame of 1 payload byte takes 4 transfers, so RUN is reached after 4 cycles.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum (ADDR, LEN, DATA, CHK, RUN, ERR);
  - the frame field order as constants;
  - `LOADER_SUM_OK` = 8'h00.
- One sub-module, `loader_checksum`, holds the 8-bit accumulator with clear, add-enable and a `match` output for a candidate CHK byte. Everything else is a single FSM in `program_loader`.

## Test plan
- Frame 10,02,AA,BB,CC,CHK=CF with `in_valid` held high → writes AA@10, BB@11, CC@12 on consecutive cycles; `done`=1 and `cpu_rst_n`=1 after the CHK edge.
- Frame FE,03,01,02,03,04,CHK=F6 → writes land at FE, FF, 00, 01 (wrap); `done`=1.
- Same as the first frame but CHK=00 → memory is written, `err`=1, `cpu_rst_n` stays 0, `done`=0. Then `load_req` pulse plus a correct frame → `done`=1 and `err`=0.
- `in_valid` toggled 1,0,0,1 within a DATA burst → `mem_write` pulses only on transfer cycles, with addresses contiguous.
- Assert `rst` after the second payload byte of a 4-byte frame → all outputs return to reset values immediately; only the first two memory locations are modified; a fresh frame then loads correctly.
- LEN=FF with 256 bytes of 0x01 and CHK=00 → 256 writes with the start address reached again at the end; `done`=1.
